usb_tx_controller: RTL and testbench

- Packet-level sequencer for the USB TX path. Drives the bit timer (shift strobe / byte-done generator) through enable_timer and consumes its shift_enable and byte_sent strobes.
- Emits, in order, SYNC, PID, payload bytes from the TX FIFO, CRC16 and EOP to the shift register / NRZI encoder.
- Sits between the AHB-side packet request logic and the serial TX datapath.

---
 rtl/usb_tx_pkg.sv | 80 ++++++++
 rtl/usb_crc16.sv | 38 +++
 rtl/usb_tx_controller.sv | 219 +++++++++++++++++++++
 tb/tb_usb_tx_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB TX packet sequencer:
//   - tx_state_t      : sequencer state encoding
//   - PKT_*           : request codes presented on tx_packet
//   - PID_*           : PID bytes placed on the wire for each request
//   - SYNC_BYTE       : first byte of every packet
//   - CRC_INIT/POLY_R : USB CRC16 seed and reflected polynomial
// Helper functions map request codes to PIDs and advance the CRC by a byte.
// ---------------------------------------------------------------------------
package usb_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_SYNC = 4'd1,
    ST_SYNC      = 4'd2,
    ST_PID       = 4'd3,
    ST_DATA      = 4'd4,
    ST_CRC_LO    = 4'd5,
    ST_CRC_HI    = 4'd6,
    ST_EOP       = 4'd7,
    ST_DONE      = 4'd8
  } tx_state_t;

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R = 16'hA001;

  // True for codes that start a packet (DATA0 through STALL).
  function automatic logic is_valid_req(input logic [2:0] code);
    return (code >= PKT_DATA0) && (code <= PKT_STALL);
  endfunction

  // True for codes that carry a payload and CRC16.
  function automatic logic is_data_pkt(input logic [2:0] code);
    return (code == PKT_DATA0) || (code == PKT_DATA1);
  endfunction

  // PID byte for a latched request code; unused codes never reach here.
  function automatic logic [7:0] pid_for(input logic [2:0] code);
    logic [7:0] pid;
    pid = PID_DATA0;
    case (code)
      PKT_DATA0: pid = PID_DATA0;
      PKT_DATA1: pid = PID_DATA1;
      PKT_ACK:   pid = PID_ACK;
      PKT_NAK:   pid = PID_NAK;
      PKT_STALL: pid = PID_STALL;
      default:   pid = PID_DATA0;
    endcase
    return pid;
  endfunction

  // One byte of reflected CRC16: fold the byte into the low bits, then
  // shift right eight times, folding in the polynomial on each carry out.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY_R;
      else      c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// ---------------------------------------------------------------------------
// usb_crc16
// Running USB CRC16 over payload bytes, one byte per enabled cycle.
// Ports:
//   clk, n_rst : clock and asynchronous active-low reset (crc -> CRC_INIT)
//   init       : reload CRC_INIT at the start of a packet (wins over enable)
//   enable     : fold data into the running crc this cycle
//   data       : payload byte being transmitted
//   crc        : current (non-inverted) register value
// ---------------------------------------------------------------------------
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_next;

  // Byte-parallel next value, computed from the same-cycle data byte.
  assign crc_next = crc16_byte(crc, data);

  // Register holds the running remainder; init restarts it per packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/usb_tx_controller.sv
// ---------------------------------------------------------------------------
// usb_tx_controller
// Packet sequencer for the USB TX path: SYNC, PID, payload, CRC16, EOP.
// Ports:
//   clk, n_rst          : clock and asynchronous active-low reset
//   tx_packet           : request code sampled in IDLE (1-5 valid, 6-7 bad)
//   buffer_occupancy    : bytes in the TX FIFO (clamped to MAX_BYTES)
//   tx_packet_data      : FIFO head byte, first-word-fall-through
//   shift_enable        : bit strobe from the bit timer
//   byte_sent           : byte-complete strobe from the bit timer
//   enable_timer        : keeps the bit timer running (low clears it)
//   tx_byte, load_byte  : byte and load strobe for the shift register
//   get_tx_packet_data  : FIFO pop, coincident with the payload byte load
//   eop_se0, eop_j      : end-of-packet line states for the encoder
//   tx_active           : high whenever the sequencer is not IDLE
//   tx_done, tx_error   : single-cycle completion / bad-request pulses
// All outputs are registered and change together with the state.
// ---------------------------------------------------------------------------
module usb_tx_controller
  import usb_tx_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       tx_packet,
  input  logic [CNT_W-1:0] buffer_occupancy,
  input  logic [7:0]       tx_packet_data,
  input  logic             shift_enable,
  input  logic             byte_sent,
  output logic             enable_timer,
  output logic [7:0]       tx_byte,
  output logic             load_byte,
  output logic             get_tx_packet_data,
  output logic             eop_se0,
  output logic             eop_j,
  output logic             tx_active,
  output logic             tx_done,
  output logic             tx_error
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  tx_state_t        state;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       eop_cnt;
  logic [15:0]      crc;

  logic             req_valid;
  logic             pkt_is_data;
  logic [CNT_W-1:0] occ_clamped;
  logic             payload_step;

  // Request qualification and payload-length clamp for the IDLE decision.
  assign req_valid   = (state == ST_IDLE) && is_valid_req(tx_packet);
  assign pkt_is_data = is_data_pkt(code_q);
  assign occ_clamped = (buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy;

  // A payload byte goes out on byte_sent in PID (data packets) or DATA
  // while bytes remain; the CRC folds in that same-cycle FIFO head.
  assign payload_step = byte_sent && (cnt != '0) &&
                        ((state == ST_DATA) || ((state == ST_PID) && pkt_is_data));

  usb_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .init   (req_valid),
    .enable (payload_step),
    .data   (tx_packet_data),
    .crc    (crc)
  );

  // Sequencer. Outputs are assigned on the transitions into the states
  // that own them, so they line up with the state register cycle-for-cycle.
  // Strobes default low each cycle and are raised only where they fire.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= ST_IDLE;
      code_q             <= PKT_NONE;
      cnt                <= '0;
      eop_cnt            <= 2'd0;
      enable_timer       <= 1'b0;
      tx_byte            <= 8'h00;
      load_byte          <= 1'b0;
      get_tx_packet_data <= 1'b0;
      eop_se0            <= 1'b0;
      eop_j              <= 1'b0;
      tx_active          <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      load_byte          <= 1'b0;
      get_tx_packet_data <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (is_valid_req(tx_packet)) begin
            code_q    <= tx_packet;
            cnt       <= is_data_pkt(tx_packet) ? occ_clamped : '0;
            tx_byte   <= SYNC_BYTE;
            load_byte <= 1'b1;
            tx_active <= 1'b1;
            state     <= ST_LOAD_SYNC;
          end else if (tx_packet != PKT_NONE) begin
            tx_error <= 1'b1;
          end
        end

        // SYNC is already loaded; start the timer so it shifts out.
        ST_LOAD_SYNC: begin
          enable_timer <= 1'b1;
          state        <= ST_SYNC;
        end

        ST_SYNC: begin
          if (byte_sent) begin
            tx_byte   <= pid_for(code_q);
            load_byte <= 1'b1;
            state     <= ST_PID;
          end
        end

        ST_PID: begin
          if (byte_sent) begin
            if (!pkt_is_data) begin
              eop_se0 <= 1'b1;
              eop_cnt <= 2'd0;
              state   <= ST_EOP;
            end else if (cnt != '0) begin
              tx_byte            <= tx_packet_data;
              load_byte          <= 1'b1;
              get_tx_packet_data <= 1'b1;
              cnt                <= cnt - CNT_W'(1);
              state              <= ST_DATA;
            end else begin
              tx_byte   <= ~crc[7:0];
              load_byte <= 1'b1;
              state     <= ST_CRC_LO;
            end
          end
        end

        ST_DATA: begin
          if (byte_sent) begin
            if (cnt != '0) begin
              tx_byte            <= tx_packet_data;
              load_byte          <= 1'b1;
              get_tx_packet_data <= 1'b1;
              cnt                <= cnt - CNT_W'(1);
            end else begin
              tx_byte   <= ~crc[7:0];
              load_byte <= 1'b1;
              state     <= ST_CRC_LO;
            end
          end
        end

        // The CRC register is frozen once the last payload byte is folded,
        // so the high byte read here matches the low byte sent before it.
        ST_CRC_LO: begin
          if (byte_sent) begin
            tx_byte   <= ~crc[15:8];
            load_byte <= 1'b1;
            state     <= ST_CRC_HI;
          end
        end

        ST_CRC_HI: begin
          if (byte_sent) begin
            eop_se0 <= 1'b1;
            eop_cnt <= 2'd0;
            state   <= ST_EOP;
          end
        end

        // EOP is SE0 for two bit times then J for one, timed by strobes.
        ST_EOP: begin
          if (shift_enable) begin
            case (eop_cnt)
              2'd0: begin
                eop_cnt <= 2'd1;
              end
              2'd1: begin
                eop_se0 <= 1'b0;
                eop_j   <= 1'b1;
                eop_cnt <= 2'd2;
              end
              default: begin
                eop_j        <= 1'b0;
                enable_timer <= 1'b0;
                tx_done      <= 1'b1;
                eop_cnt      <= 2'd0;
                state        <= ST_DONE;
              end
            endcase
          end
        end

        ST_DONE: begin
          tx_active <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          enable_timer <= 1'b0;
          eop_se0      <= 1'b0;
          eop_j        <= 1'b0;
          tx_active    <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_controller.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_controller
// Directed bench for usb_tx_controller. A small bit-timer model produces
// shift_enable every 2 cycles and byte_sent on every 8th strobe while
// enable_timer is high; a FIFO model presents fifo[idx] and advances on pops.
// Loaded bytes are logged and compared against hand-built expectations,
// with CRC bytes from an independent bit-serial CRC16 model.
// ---------------------------------------------------------------------------
module tb_usb_tx_controller;

  logic       clk;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       shift_enable;
  logic       byte_sent;
  logic       enable_timer;
  logic [7:0] tx_byte;
  logic       load_byte;
  logic       get_tx_packet_data;
  logic       eop_se0;
  logic       eop_j;
  logic       tx_active;
  logic       tx_done;
  logic       tx_error;

  int checks;
  int failures;

  logic [7:0] fifo [0:127];
  logic [6:0] fifoIdx;
  bit         popPending;
  int         tmrCycles;
  int         tmrBits;

  logic [7:0] loads[$];
  logic [7:0] expBytes[$];
  int loadCycles[$];
  int cycleCount;
  int pops, popWithoutLoad, se0Strobes, jStrobes;
  int doneCycles, errorPulses, activeCycles;
  int reqCycle;
  logic [15:0] crcExp;

  usb_tx_controller #(.MAX_BYTES(64), .CNT_W(7)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .shift_enable       (shift_enable),
    .byte_sent          (byte_sent),
    .enable_timer       (enable_timer),
    .tx_byte            (tx_byte),
    .load_byte          (load_byte),
    .get_tx_packet_data (get_tx_packet_data),
    .eop_se0            (eop_se0),
    .eop_j              (eop_j),
    .tx_active          (tx_active),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference CRC16 over fifo[0..n-1], LSB of each byte first.
  function automatic logic [15:0] crcRef(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fifo[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample just after the edge, log, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cycleCount++;
    if (popPending) fifoIdx = fifoIdx + 7'd1;
    popPending = 1'b0;
    if (load_byte) begin
      loads.push_back(tx_byte);
      loadCycles.push_back(cycleCount);
    end
    if (get_tx_packet_data) begin
      pops++;
      popPending = 1'b1;
      if (!load_byte) popWithoutLoad++;
    end
    if (tx_done)   doneCycles++;
    if (tx_error)  errorPulses++;
    if (tx_active) activeCycles++;
    tx_packet_data = fifo[fifoIdx];
    shift_enable = 1'b0;
    byte_sent    = 1'b0;
    if (enable_timer) begin
      tmrCycles++;
      if (tmrCycles == 2) begin
        tmrCycles    = 0;
        shift_enable = 1'b1;
        tmrBits++;
        if (tmrBits == 8) begin
          tmrBits   = 0;
          byte_sent = 1'b1;
        end
      end
    end else begin
      tmrCycles = 0;
      tmrBits   = 0;
    end
    if (shift_enable && eop_se0) se0Strobes++;
    if (shift_enable && eop_j)   jStrobes++;
  endtask

  task automatic clearLogs();
    loads.delete();
    loadCycles.delete();
    pops = 0; popWithoutLoad = 0; se0Strobes = 0; jStrobes = 0;
    doneCycles = 0; errorPulses = 0; activeCycles = 0;
    fifoIdx = 7'd0; popPending = 1'b0;
    tx_packet_data = fifo[0];
  endtask

  // Issue one request for a single cycle and run until tx_done (bounded).
  task automatic applyStimulus(input logic [2:0] code, input logic [6:0] occ,
                               input int budget);
    clearLogs();
    reqCycle = cycleCount;
    tx_packet = code;
    buffer_occupancy = occ;
    step();
    tx_packet = 3'd0;
    for (int i = 0; i < budget && doneCycles == 0; i++) step();
    step();
    step();
  endtask

  task automatic checkBytes(input string tag);
    checkOutput($sformatf("%s_load_count", tag), loads.size(), expBytes.size());
    for (int i = 0; i < expBytes.size() && i < loads.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, loads[i]}, {24'h0, expBytes[i]});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tx_byte"}, {24'h0, tx_byte}, 32'h0);
    checkOutput({tag, "_flags"},
                {24'h0, enable_timer, load_byte, get_tx_packet_data, eop_se0,
                 eop_j, tx_active, tx_done, tx_error}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cycleCount = 0;
    tmrCycles = 0; tmrBits = 0;
    for (int i = 0; i < 128; i++) fifo[i] = 8'(i * 5 + 1);
    n_rst = 1'b0;
    tx_packet = 3'd0;
    buffer_occupancy = 7'd0;
    shift_enable = 1'b0;
    byte_sent = 1'b0;
    clearLogs();

    // Reset state
    #12;
    checkAllZero("reset");
    #10;
    n_rst = 1'b1;
    step();

    // ACK handshake
    $display("[TB] ACK packet");
    applyStimulus(3'd3, 7'd0, 500);
    expBytes = {8'h80, 8'hD2};
    checkBytes("ack");
    checkOutput("ack_sync_latency", loadCycles.size() > 0 ? loadCycles[0] : -1, reqCycle + 1);
    checkOutput("ack_pops", pops, 0);
    checkOutput("ack_se0_strobes", se0Strobes, 2);
    checkOutput("ack_j_strobes", jStrobes, 1);
    checkOutput("ack_done_cycles", doneCycles, 1);
    checkOutput("ack_active_after", {31'h0, tx_active}, 32'h0);

    // DATA0, empty payload
    $display("[TB] DATA0 zero length");
    applyStimulus(3'd1, 7'd0, 1000);
    expBytes = {8'h80, 8'hC3, 8'h00, 8'h00};
    checkBytes("d0z");
    checkOutput("d0z_pops", pops, 0);
    checkOutput("d0z_done_cycles", doneCycles, 1);

    // DATA1, three payload bytes
    $display("[TB] DATA1 three bytes");
    fifo[0] = 8'h01; fifo[1] = 8'h02; fifo[2] = 8'h03;
    crcExp = crcRef(3);
    applyStimulus(3'd2, 7'd3, 2000);
    expBytes = {8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, ~crcExp[7:0], ~crcExp[15:8]};
    checkBytes("d1");
    checkOutput("d1_pops", pops, 3);
    checkOutput("d1_pop_without_load", popWithoutLoad, 0);
    checkOutput("d1_done_cycles", doneCycles, 1);

    // Invalid request code
    $display("[TB] invalid request");
    clearLogs();
    tx_packet = 3'd7;
    step();
    tx_packet = 3'd0;
    for (int i = 0; i < 6; i++) step();
    checkOutput("bad_error_pulses", errorPulses, 1);
    checkOutput("bad_active_cycles", activeCycles, 0);
    checkOutput("bad_loads", loads.size(), 0);

    // Asynchronous reset in the middle of a DATA packet
    $display("[TB] reset mid-packet");
    for (int i = 0; i < 128; i++) fifo[i] = 8'(i * 5 + 1);
    clearLogs();
    tx_packet = 3'd2;
    buffer_occupancy = 7'd5;
    step();
    tx_packet = 3'd0;
    for (int i = 0; i < 600 && pops < 2; i++) step();
    checkOutput("midrst_reached_data", pops, 2);
    #2;
    n_rst = 1'b0;
    #1;
    checkAllZero("midrst");
    shift_enable = 1'b0;
    byte_sent = 1'b0;
    #13;
    n_rst = 1'b1;
    step();
    applyStimulus(3'd4, 7'd0, 500);
    expBytes = {8'h80, 8'h5A};
    checkBytes("nak");
    checkOutput("nak_done_cycles", doneCycles, 1);

    // Occupancy above MAX_BYTES is clamped to 64
    $display("[TB] occupancy clamp");
    crcExp = crcRef(64);
    applyStimulus(3'd1, 7'd100, 3000);
    checkOutput("clamp_pops", pops, 64);
    checkOutput("clamp_load_count", loads.size(), 68);
    if (loads.size() == 68) begin
      checkOutput("clamp_last_payload", {24'h0, loads[65]}, {24'h0, fifo[63]});
      checkOutput("clamp_crc_lo", {24'h0, loads[66]}, {24'h0, ~crcExp[7:0]});
      checkOutput("clamp_crc_hi", {24'h0, loads[67]}, {24'h0, ~crcExp[15:8]});
    end
    checkOutput("clamp_done_cycles", doneCycles, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
